// File: rtl/solver_sequencer.sv
// Sequencer for the drum-membrane solver grid: sample-rate timestep pulses, a
// solver reset per strike, and mid-node capture with a valid/ready + overrun handshake.
// Optional macro RHO_TENSION_EN: rho follows the tension-modulated value captured per sample.
module solver_sequencer #(
    parameter int                 SAMPLE_DIV    = 1042,
    parameter int                 INIT_CYCLES   = 2,
    parameter int                 SETTLE_CYCLES = 2,
    parameter int                 NUM_SAMPLES   = 48000,
    parameter int                 TENSION_SHIFT = 4,
    parameter logic signed [17:0] RHO_MAX       = 18'sh0F000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               strike,
    input  logic signed [17:0] rho_base,
    input  logic signed [17:0] mid_node,
    output logic               solver_reset,
    output logic               solver_enable,
    output logic signed [17:0] rho,
    output logic signed [17:0] sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun,
    output logic               busy
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (IW > SW) ? IW : SW;
    localparam int CW = $clog2(NUM_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(SAMPLE_DIV - 1);
    localparam logic [PW-1:0] INIT_LAST   = PW'(INIT_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_LAST  = CW'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_TICK,
        STEP,
        SETTLE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [PW-1:0]   phase_cnt;
    logic [CW-1:0]   sample_count;
    logic            capture;

    // Free-running sample-rate divider, independent of the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A strike landing on the last settle cycle cancels that capture.
    assign capture = (state == SETTLE) && (phase_cnt == SETTLE_LAST) && !strike;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (strike || (state_nxt != state) || !((state == INIT) || (state == SETTLE))) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        solver_reset  = 1'b0;
        solver_enable = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                solver_reset = 1'b1;
                busy         = 1'b0;
            end
            INIT: begin
                solver_reset = 1'b1;
                if (phase_cnt == INIT_LAST) begin
                    state_nxt = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                solver_enable = 1'b1;
                state_nxt     = SETTLE;
            end
            SETTLE: begin
                if (phase_cnt == SETTLE_LAST) begin
                    state_nxt = (sample_count == COUNT_LAST) ? IDLE : WAIT_TICK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (strike) begin
            state_nxt = INIT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            sample_count <= '0;
        end else begin
            if (state == INIT) begin
                sample_count <= '0;
                overrun      <= 1'b0;
            end
            if (capture) begin
                sample_out   <= mid_node;
                sample_valid <= 1'b1;
                sample_count <= sample_count + 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef RHO_TENSION_EN
    localparam logic signed [18:0] POS_LIM = 19'sh1FFFF;
    localparam logic signed [18:0] NEG_LIM = 19'sh60000;

    logic signed [18:0] mid_ext;
    logic signed [18:0] mid_abs;
    logic signed [18:0] rho_sum;
    logic signed [18:0] rho_lim;
    logic signed [18:0] rho_max_ext;
    logic signed [17:0] rho_sat;

    // 19 bits holds |-2^17| and the worst-case sum without wrapping.
    always_comb begin
        rho_max_ext = {RHO_MAX[17], RHO_MAX};
        mid_ext     = {mid_node[17], mid_node};
        mid_abs     = mid_ext[18] ? -mid_ext : mid_ext;
        rho_sum     = {rho_base[17], rho_base} + (mid_abs >>> TENSION_SHIFT);
        rho_lim     = (rho_sum > rho_max_ext) ? rho_max_ext : rho_sum;
        if (rho_lim > POS_LIM) begin
            rho_sat = 18'sh1FFFF;
        end else if (rho_lim < NEG_LIM) begin
            rho_sat = 18'sh20000;
        end else begin
            rho_sat = rho_lim[17:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rho <= '0;
        end else if (state == INIT) begin
            rho <= rho_base;
        end else if (capture) begin
            rho <= rho_sat;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rho <= '0;
        end else begin
            rho <= rho_base;
        end
    end
`endif

endmodule

// File: tb/tb_solver_sequencer.sv
// Randomized self-checking bench for solver_sequencer against an event-schedule reference model.
module tb_solver_sequencer;

    localparam int DIV    = 8;
    localparam int INIT   = 2;
    localparam int SETTLE = 2;
    localparam int NS     = 4;
    localparam int SHIFT  = 4;
    localparam int RMAX   = 'h0F000;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               strike = 1'b0;
    logic               sample_ready = 1'b0;
    logic signed [17:0] rho_base = '0;
    logic signed [17:0] mid_node = '0;
    logic               solver_reset, solver_enable, sample_valid, overrun, busy;
    logic signed [17:0] rho, sample_out;

    solver_sequencer #(
        .SAMPLE_DIV(DIV), .INIT_CYCLES(INIT), .SETTLE_CYCLES(SETTLE), .NUM_SAMPLES(NS),
        .TENSION_SHIFT(SHIFT), .RHO_MAX(18'sh0F000)
    ) dut (
        .clock(clock), .reset(reset), .strike(strike), .rho_base(rho_base), .mid_node(mid_node),
        .solver_reset(solver_reset), .solver_enable(solver_enable), .rho(rho),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    // Cycle index since reset release; the divider is at cyc % DIV.
    int cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int compared = 0;
    int mismatched = 0;

    // Reference model: schedule of the latest strike plus handshake state.
    bit                 sched_on;
    int                 s;
    bit                 pend, ovr;
    logic signed [17:0] samp;
    int                 rho_m;
    bit                 e_busy, e_sreset, e_en;

    function automatic int first_en(input int st);
        int c = st + 1 + INIT;
        while (c % DIV != DIV - 1) c++;
        return c + 1;
    endfunction

    function automatic bit cap_now();
        int e0, el;
        if (!sched_on || cyc <= s) return 1'b0;
        e0 = first_en(s);
        el = e0 + DIV * (NS - 1);
        return (cyc >= e0 + SETTLE) && (cyc <= el + SETTLE) && ((cyc - e0 - SETTLE) % DIV == 0);
    endfunction

    function automatic int tension(input int rb, input int mid);
        int a = (mid < 0) ? -mid : mid;
        int t = rb + (a >> SHIFT);
        if (t > RMAX) t = RMAX;
        return t;
    endfunction

    task automatic calc_exp();
        int e0, el;
        e_busy = 1'b0; e_sreset = 1'b1; e_en = 1'b0;
        if (sched_on) begin
            e0 = first_en(s);
            el = e0 + DIV * (NS - 1);
            if (cyc > s && cyc < el + SETTLE + 1) begin
                e_busy   = 1'b1;
                e_sreset = (cyc <= s + INIT);
                e_en     = (cyc >= e0) && ((cyc - e0) % DIV == 0) && (cyc <= el);
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, land on the next negedge.
    task automatic advance(input bit st, input bit rdy, input logic signed [17:0] mid,
                           input logic signed [17:0] rb);
        bit cap, init_now;
        strike = st; sample_ready = rdy; mid_node = mid; rho_base = rb;
        cap      = cap_now() && !st;
        init_now = sched_on && (cyc > s) && (cyc <= s + INIT);
        if (cap) begin
            if (pend && !rdy) ovr = 1'b1;
            pend = 1'b1;
            samp = mid;
        end else if (pend && rdy) begin
            pend = 1'b0;
        end
        if (init_now) ovr = 1'b0;
`ifdef RHO_TENSION_EN
        if (init_now)  rho_m = int'(rb);
        else if (cap)  rho_m = tension(int'(rb), int'(mid));
`else
        rho_m = int'(rb);
`endif
        if (st) begin
            sched_on = 1'b1;
            s = cyc;
        end
        @(negedge clock);
        calc_exp();
    endtask

    task automatic reset_dut();
        reset = 1'b1; strike = 1'b0; sample_ready = 1'b0; mid_node = '0; rho_base = '0;
        @(negedge clock);
        @(negedge clock);
        sched_on = 1'b0; s = 0; pend = 1'b0; ovr = 1'b0; samp = '0; rho_m = 0;
        reset = 1'b0;
        calc_exp();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        compared++;
        if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== 5'b01000 ||
            rho !== 18'sd0 || sample_out !== 18'sd0) begin
            mismatched++;
            $display("FAIL reset_values got ctl=%b rho=%h out=%h want ctl=01000 rho=0 out=0",
                     {busy, solver_reset, solver_enable, sample_valid, overrun}, rho, sample_out);
        end
    endtask

    // Plain strike with a permanently ready consumer and constant mid_node.
    task automatic test_basic();
        int en_cyc[$];
        int idle = $urandom_range(0, 9);
        reset_dut();
        for (int i = 0; i < idle + 60; i++) begin
            compared++;
            if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== {e_busy, e_sreset, e_en, pend, ovr}
                || sample_out !== samp) begin
                mismatched++;
                $display("FAIL basic_cycle cyc=%0d got ctl=%b out=%h want ctl=%b out=%h", cyc,
                         {busy, solver_reset, solver_enable, sample_valid, overrun}, sample_out,
                         {e_busy, e_sreset, e_en, pend, ovr}, samp);
            end
            if (solver_enable) en_cyc.push_back(cyc);
            if (en_cyc.size() > 0 && cyc == en_cyc[$] + 3) begin
                compared++;
                if (!sample_valid || sample_out !== 18'sh00100) begin
                    mismatched++;
                    $display("FAIL basic_sample cyc=%0d got valid=%b out=%h want valid=1 out=00100",
                             cyc, sample_valid, sample_out);
                end
            end
            advance(i == idle, 1'b1, 18'sh00100, 18'sd0);
        end
        compared++;
        if (en_cyc.size() != 4) begin
            mismatched++;
            $display("FAIL basic_pulse_count got %0d want 4", en_cyc.size());
        end
        for (int k = 1; k < en_cyc.size(); k++) begin
            compared++;
            if (en_cyc[k] - en_cyc[k-1] != 8) begin
                mismatched++;
                $display("FAIL basic_spacing got %0d want 8", en_cyc[k] - en_cyc[k-1]);
            end
        end
        compared++;
        if (busy !== 1'b0 || solver_reset !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_idle got busy=%b sreset=%b want busy=0 sreset=1", busy, solver_reset);
        end
    endtask

    // Consumer never ready (mode 0) or ready exactly on each capture cycle (mode 1).
    task automatic test_ready_modes(input int mode);
        for (int i = 0; i < 60; i++) begin
            compared++;
            if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== {e_busy, e_sreset, e_en, pend, ovr}
                || sample_out !== samp) begin
                mismatched++;
                $display("FAIL ready_mode%0d_cycle cyc=%0d got ctl=%b out=%h want ctl=%b out=%h", mode, cyc,
                         {busy, solver_reset, solver_enable, sample_valid, overrun}, sample_out,
                         {e_busy, e_sreset, e_en, pend, ovr}, samp);
            end
            advance(i == 0, (mode == 1) && cap_now(), 18'($urandom_range(1, 'h3FFFF)), 18'sd0);
        end
        compared++;
        if (sample_valid !== 1'b1 || overrun !== (mode == 0) || sample_out !== samp) begin
            mismatched++;
            $display("FAIL ready_mode%0d_end got valid=%b ovr=%b out=%h want valid=1 ovr=%b out=%h",
                     mode, sample_valid, overrun, sample_out, mode == 0, samp);
        end
    endtask

    task automatic test_no_ready();
        reset_dut();
        test_ready_modes(0);
    endtask

    task automatic test_ready_same_cycle();
        reset_dut();
        test_ready_modes(1);
    endtask

    // Re-strike in the settle window of the second sample.
    task automatic test_restrike();
        int rs, rises_before = 0, rises_after = 0;
        bit prev_v = 1'b0, done = 1'b0;
        reset_dut();
        rs = 0;
        for (int i = 0; i < 100; i++) begin
            compared++;
            if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== {e_busy, e_sreset, e_en, pend, ovr}
                || sample_out !== samp) begin
                mismatched++;
                $display("FAIL restrike_cycle cyc=%0d got ctl=%b out=%h want ctl=%b out=%h", cyc,
                         {busy, solver_reset, solver_enable, sample_valid, overrun}, sample_out,
                         {e_busy, e_sreset, e_en, pend, ovr}, samp);
            end
            if (sample_valid && !prev_v) begin
                if (done) rises_after++;
                else      rises_before++;
            end
            prev_v = sample_valid;
            if (i == 0) begin
                advance(1'b1, 1'b1, 18'($urandom), 18'sd0);
                rs = first_en(s) + DIV + $urandom_range(1, SETTLE);
            end else if (!done && cyc == rs) begin
                done = 1'b1;
                advance(1'b1, 1'b1, 18'($urandom), 18'sd0);
            end else begin
                advance(1'b0, 1'b1, 18'($urandom), 18'sd0);
            end
        end
        compared++;
        if (rises_before != 1 || rises_after != 4) begin
            mismatched++;
            $display("FAIL restrike_counts got before=%0d after=%0d want before=1 after=4",
                     rises_before, rises_after);
        end
    endtask

    task automatic test_reset_during_step();
        int target;
        bit hit = 1'b0;
        reset_dut();
        advance(1'b1, 1'b0, 18'($urandom_range(1, 'h1FFFF)), 18'sh01234);
        target = first_en(s) + DIV;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (cyc == target) hit = 1'b1;
            else advance(1'b0, 1'b0, 18'($urandom_range(1, 'h1FFFF)), 18'sh01234);
        end
        compared++;
        if (!hit || solver_enable !== 1'b1 || sample_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL step_reached got hit=%b en=%b valid=%b want 1 1 1", hit, solver_enable, sample_valid);
        end
        #2 reset = 1'b1;
        #1;
        compared++;
        if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== 5'b01000 ||
            rho !== 18'sd0 || sample_out !== 18'sd0) begin
            mismatched++;
            $display("FAIL step_async_reset got ctl=%b rho=%h out=%h want ctl=01000 rho=0 out=0",
                     {busy, solver_reset, solver_enable, sample_valid, overrun}, rho, sample_out);
        end
        @(negedge clock);
        compared++;
        if (solver_enable !== 1'b0 || sample_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL step_reset_hold got en=%b valid=%b want 0 0", solver_enable, sample_valid);
        end
    endtask

    task automatic test_random();
        logic signed [17:0] er;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            er = 18'(rho_m);
            compared++;
            if ({busy, solver_reset, solver_enable, sample_valid, overrun} !== {e_busy, e_sreset, e_en, pend, ovr}
                || sample_out !== samp || rho !== er) begin
                mismatched++;
                $display("FAIL random_cycle cyc=%0d got ctl=%b out=%h rho=%h want ctl=%b out=%h rho=%h", cyc,
                         {busy, solver_reset, solver_enable, sample_valid, overrun}, sample_out, rho,
                         {e_busy, e_sreset, e_en, pend, ovr}, samp, er);
            end
            advance((i == 0) || ($urandom_range(0, 49) == 0), 1'($urandom), 18'($urandom), 18'($urandom));
        end
    endtask

    task automatic test_rho();
`ifdef RHO_TENSION_EN
        int e0;
        reset_dut();
        advance(1'b1, 1'b1, 18'sh20000, 18'sh0E000);
        e0 = first_en(s);
        for (int i = 0; i < 40; i++) begin
            if (cyc == e0 - 1) begin
                compared++;
                if (rho !== 18'sh0E000) begin
                    mismatched++;
                    $display("FAIL rho_init got %h want 0E000", rho);
                end
            end
            if (cyc == e0 + SETTLE + 1) begin
                compared++;
                if (rho !== 18'sh0F000) begin
                    mismatched++;
                    $display("FAIL rho_saturated got %h want 0F000", rho);
                end
            end
            advance(1'b0, 1'b1, 18'sh20000, 18'sh0E000);
        end
`else
        logic signed [17:0] prev, rb;
        reset_dut();
        prev = '0;
        for (int i = 0; i < 12; i++) begin
            compared++;
            if (rho !== prev) begin
                mismatched++;
                $display("FAIL rho_latency cyc=%0d got %h want %h", cyc, rho, prev);
            end
            rb = 18'($urandom);
            advance(i == 0, 1'b1, 18'($urandom), rb);
            prev = rb;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_ready();
        test_ready_same_cycle();
        test_restrike();
        test_reset_during_step();
        test_rho();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/solver_sequencer.md
SOLVER_SEQUENCER -- requirements
Module: solver_sequencer

Interface
REQ-001 The block SHALL have a parameter SAMPLE_DIV, default 1042: clock cycles per audio sample tick.
REQ-002 The block SHALL have a parameter INIT_CYCLES, default 2: cycles solver_reset is held after a strike.
REQ-003 The block SHALL have a parameter SETTLE_CYCLES, default 2: cycles from the enable pulse to a valid mid_node.
REQ-004 The block SHALL have a parameter NUM_SAMPLES, default 48000: samples produced per strike before returning to IDLE.
REQ-005 The block SHALL have a parameter TENSION_SHIFT, default 4, and a parameter RHO_MAX, default 18'sh0F000; both are used only under RHO_TENSION_EN.
REQ-006 The block SHALL have a port clock, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high.
REQ-008 The block SHALL have a port strike, input, 1 bit: single-cycle pulse that (re)starts a drum hit.
REQ-009 The block SHALL have a port rho_base, input, 18-bit signed: base rho in 1.17 fixed point.
REQ-010 The block SHALL have a port mid_node, input, 18-bit signed: middle-node value from the patch grid.
REQ-011 The block SHALL have a port solver_reset, output, 1 bit: drives the grid reset, reloading the initial hit.
REQ-012 The block SHALL have a port solver_enable, output, 1 bit: single-cycle timestep enable to the grid.
REQ-013 The block SHALL have a port rho, output, 18-bit signed: rho to the grid.
REQ-014 The block SHALL have a port sample_out, output, 18-bit signed: captured audio sample.
REQ-015 The block SHALL have a port sample_valid, output, 1 bit: sample_out is valid.
REQ-016 The block SHALL have a port sample_ready, input, 1 bit: consumer accepts the sample.
REQ-017 The block SHALL have a port overrun, output, 1 bit: sticky flag, a sample was overwritten before it was accepted.
REQ-018 The block SHALL have a port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 The tick counter SHALL count 0..SAMPLE_DIV-1 and wrap continuously; tick is asserted when the count equals SAMPLE_DIV-1.
REQ-020 The FSM SHALL have the states IDLE, INIT, WAIT_TICK, STEP and SETTLE.
REQ-021 In IDLE, solver_reset=1 and solver_enable=0; strike moves the FSM to INIT.
REQ-022 INIT SHALL hold solver_reset=1 for exactly INIT_CYCLES cycles, clear sample_count and overrun, then go to WAIT_TICK.
REQ-023 In WAIT_TICK, solver_reset=0; tick moves the FSM to STEP.
REQ-024 STEP SHALL assert solver_enable for exactly one cycle, then go to SETTLE.
REQ-025 SETTLE SHALL wait SETTLE_CYCLES cycles; on its last cycle it registers mid_node into sample_out, sets sample_valid, and increments sample_count.
REQ-026 After SETTLE, the FSM SHALL return to WAIT_TICK, or go to IDLE when sample_count reaches NUM_SAMPLES.
REQ-027 sample_valid SHALL remain high until a cycle in which sample_valid and sample_ready are both high; it drops the following cycle unless a capture occurs in that same cycle.
REQ-028 A capture while sample_valid=1 and sample_ready=0 SHALL overwrite sample_out, keep sample_valid=1, and set overrun; a simultaneous capture and accept is not an overrun.
REQ-029 A strike in any state SHALL force INIT with a restarted INIT count; a pending sample_valid is unaffected by the strike.
REQ-030 Parameters SHALL satisfy SAMPLE_DIV >= SETTLE_CYCLES+3, which guarantees no tick arrives outside WAIT_TICK in steady state; a tick that arrives outside WAIT_TICK is ignored.
REQ-031 Without RHO_TENSION_EN, rho SHALL be rho_base registered every cycle, giving one cycle of latency.

Reset
REQ-032 While reset=1, the outputs SHALL be: solver_reset=1, solver_enable=0, rho=0, sample_out=0, sample_valid=0, overrun=0, busy=0; the FSM is in IDLE and all counters are 0.
REQ-033 Asserting reset mid-operation SHALL abort immediately, with no enable pulse and no capture completing.

Configuration
REQ-034 Macro RHO_TENSION_EN defined: at each capture, rho SHALL be set to min(rho_base + (|mid_node| >>> TENSION_SHIFT), RHO_MAX), computed at 19 bits and saturated to 18 bits; the value is held between captures and rho is set to rho_base in INIT.
REQ-035 Macro RHO_TENSION_EN undefined: REQ-031 SHALL apply, and TENSION_SHIFT and RHO_MAX have no effect.

Verification
Common settings: SAMPLE_DIV=8, INIT_CYCLES=2, SETTLE_CYCLES=2, NUM_SAMPLES=4.
REQ-036 Bench SHALL cover: strike, sample_ready=1, mid_node=18'sh00100 -> 2 cycles of solver_reset, then 4 enable pulses spaced exactly 8 cycles, sample_out=18'sh00100 2 cycles after each pulse, then IDLE with busy=0.
REQ-037 Bench SHALL cover: sample_ready=0 for the whole run -> overrun rises at the 2nd capture, sample_valid stays 1, and sample_out holds the last captured value.
REQ-038 Bench SHALL cover: sample_ready asserted in the same cycle as a new capture -> sample_valid stays 1 and overrun stays 0.
REQ-039 Bench SHALL cover: strike during SETTLE of sample 2 -> no capture for that step, INIT restarts, sample_count restarts, and 4 more samples follow.
REQ-040 Bench SHALL cover: reset pulsed during STEP -> all outputs return to their reset values asynchronously.
REQ-041 Bench SHALL cover, with RHO_TENSION_EN, rho_base=18'sh0E000 and mid_node=-18'sh20000: rho after the capture = 18'sh0F000 (saturated).
